// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_pkg
//  Description : Shared definitions for the memory responder slice.
//                - Opcode encoding, identical to the MBR control field.
//                - Responder FSM state encoding.
//                - Default data and address widths.
//                - Helper that classifies an opcode as a read.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_FETCH = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        ACK    = 2'd3
    } state_t;

    // Fetch and load are both reads; they differ only in who consumes the data.
    function automatic logic op_is_read(input logic [1:0] op);
        return (op == OP_FETCH) || (op == OP_LOAD);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : mem_array
//  Description : Single-port synchronous RAM, DEPTH x DATA_W, no reset.
//                Read data is registered; a read during a write returns the
//                old contents.
//  Ports       : clk   - rising-edge clock
//                we    - write enable
//                addr  - word address
//                wdata - write data
//                rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for the MBR fetch/load/store path.
//                Captures a request in IDLE, waits WAIT_CYCLES, performs the
//                RAM access, then returns a one-cycle ack (qualified by err)
//                with registered read data.
//  Ports       : clk   - rising-edge clock
//                rst_n - asynchronous active-low reset
//                req   - request valid, held until ack
//                op    - 00 none, 01 fetch, 10 load, 11 store
//                addr  - word address
//                wdata - store data
//                ack   - one-cycle completion pulse
//                err   - request rejected (valid with ack)
//                rdata - read data, held until the next successful read
//                busy  - high whenever the FSM is not IDLE
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic [1:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);

    localparam int         c_ram_aw    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] c_wait_load = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [3:0]        r_cnt;
    logic              r_ack;
    logic              r_err;

    logic              w_illegal;
    logic              w_we;
    logic [DATA_W-1:0] w_ram_rdata;

    // Legality is judged on the captured request only, so it is stable from
    // WAIT through ACK regardless of what the master does with its inputs.
    assign w_illegal = (r_op == OP_NONE) || (32'(r_addr) >= 32'(DEPTH));
    assign w_we      = (r_state == ACCESS) && (r_op == OP_STORE) && !w_illegal;

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (c_ram_aw)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_we),
        .addr  (r_addr[c_ram_aw-1:0]),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    // ACK spans two cycles: the first registers the RAM output and raises
    // ack/err, the second is the visible ack cycle and then returns to IDLE.
    // r_ack doubles as the sub-phase marker within ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_op    <= OP_NONE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= 4'd0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req) begin
                        r_op    <= op;
                        r_addr  <= addr;
                        r_wdata <= wdata;
                        r_cnt   <= c_wait_load;
                        r_state <= (WAIT_CYCLES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ACCESS;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ACCESS: begin
                    r_state <= ACK;
                end
                ACK: begin
                    if (!r_ack) begin
                        r_ack <= 1'b1;
                        r_err <= w_illegal;
                        if (!w_illegal && op_is_read(r_op)) begin
                            r_rdata <= w_ram_rdata;
                        end
                    end else begin
                        r_ack   <= 1'b0;
                        r_err   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ack   = r_ack;
    assign err   = r_err;
    assign rdata = r_rdata;
    assign busy  = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Scoreboard bench for mem_responder. A driver issues directed
//                and random requests to a WAIT_CYCLES=1 instance and pushes
//                the expected response, computed from a plain array model of
//                the memory, into a queue; a monitor pops and compares on
//                every ack. Two extra instances cover WAIT_CYCLES=0 with
//                DEPTH=128 and WAIT_CYCLES=15.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    localparam logic [1:0] c_none  = 2'b00;
    localparam logic [1:0] c_fetch = 2'b01;
    localparam logic [1:0] c_load  = 2'b10;
    localparam logic [1:0] c_store = 2'b11;
    localparam int         c_lat   = 3;   // WAIT_CYCLES=1 -> 1 + 2 edges

    logic        clk = 1'b0;
    logic        rst_n, req, ack, err, busy;
    logic [1:0]  op;
    logic [7:0]  addr;
    logic [15:0] wdata, rdata;

    logic             xrst_n;
    logic [1:0]       xreq, xack, xerr, xbusy;
    logic [1:0][1:0]  xop;
    logic [1:0][7:0]  xaddr;
    logic [1:0][15:0] xwdata, xrdata;

    always #5 clk = ~clk;

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .op(op), .addr(addr), .wdata(wdata),
        .ack(ack), .err(err), .rdata(rdata), .busy(busy));

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(128), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(xrst_n), .req(xreq[0]), .op(xop[0]), .addr(xaddr[0]),
        .wdata(xwdata[0]), .ack(xack[0]), .err(xerr[0]), .rdata(xrdata[0]), .busy(xbusy[0]));

    mem_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(15)) u_dut_w15 (
        .clk(clk), .rst_n(xrst_n), .req(xreq[1]), .op(xop[1]), .addr(xaddr[1]),
        .wdata(xwdata[1]), .ack(xack[1]), .err(xerr[1]), .rdata(xrdata[1]), .busy(xbusy[1]));

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] m_ram [256];
    logic [15:0] m_rdata;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;
    logic        prev_ack = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    endfunction

    // Reference behaviour of one transaction on the WAIT_CYCLES=1 instance.
    function automatic exp_t model(input logic [1:0] o, input logic [7:0] a, input logic [15:0] d);
        exp_t e;
        if (o == c_none) begin
            e.err = 1'b1;
        end else if (o == c_store) begin
            m_ram[a] = d;
            e.err    = 1'b0;
        end else begin
            m_rdata = m_ram[a];
            e.err   = 1'b0;
        end
        e.rdata = m_rdata;
        e.cyc   = cyc;
        return e;
    endfunction

    // Called at a negedge while the DUT is idle or in its ack cycle; returns at
    // the negedge of the ack cycle with req still high.
    task automatic issue(input logic [1:0] o, input logic [7:0] a, input logic [15:0] d);
        int n;
        req = 1'b1; op = o; addr = a; wdata = d;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!busy && n < 20);
        chk("issue_sampled", 32'(busy), 32'd1);
        if (!busy) begin
            req = 1'b0;
            return;
        end
        expq.push_back(model(o, a, d));
        @(negedge clk);
        op = 2'($urandom); addr = 8'($urandom); wdata = 16'($urandom);
        n = 0;
        while (!ack && n < 40) begin
            @(negedge clk); n++;
        end
        chk("ack_seen", 32'(ack), 32'd1);
    endtask

    task automatic idle_gap();
        req = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ack <= 1'b0;
        end else begin
            if (ack) begin
                chk("ack_has_expect", 32'(expq.size() != 0), 32'd1);
                if (expq.size() != 0) begin
                    exp_t e;
                    e = expq.pop_front();
                    chk("err", 32'(err), 32'(e.err));
                    chk("rdata", 32'(rdata), 32'(e.rdata));
                    chk("latency", 32'(cyc - e.cyc), 32'(c_lat));
                    chk("busy_at_ack", 32'(busy), 32'd1);
                    chk("ack_one_cycle", 32'(prev_ack), 32'd0);
                end
            end else if (prev_ack) begin
                chk("idle_after_ack", 32'(busy), 32'd0);
            end
            prev_ack <= ack;
        end
    end

    task automatic xrun(input int i, input logic [1:0] o, input logic [7:0] a, input logic [15:0] d,
                        input int exp_lat, input logic exp_err, input logic [15:0] exp_rd);
        int lat;
        @(negedge clk);
        xreq[i] = 1'b1; xop[i] = o; xaddr[i] = a; xwdata[i] = d;
        @(posedge clk);
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!xack[i] && lat < 40);
        xreq[i] = 1'b0;
        chk($sformatf("x%0d_latency", i), 32'(lat), 32'(exp_lat));
        chk($sformatf("x%0d_err", i), 32'(xerr[i]), 32'(exp_err));
        chk($sformatf("x%0d_rdata", i), 32'(xrdata[i]), 32'(exp_rd));
        @(negedge clk);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; xrst_n = 1'b0;
        req = 1'b0; op = c_none; addr = '0; wdata = '0;
        xreq = '0; xop = '0; xaddr = '0; xwdata = '0;
        m_rdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1; xrst_n = 1'b1;
        @(negedge clk);

        // Give every word a known value.
        for (int i = 0; i < 256; i++) issue(c_store, 8'(i), 16'($urandom));
        idle_gap();

        // Store then load.
        issue(c_store, 8'h05, 16'h1234); idle_gap();
        issue(c_load,  8'h05, 16'h0000); idle_gap();

        // Reset during WAIT aborts a pending store.
        req = 1'b1; op = c_store; addr = 8'h05; wdata = 16'hFFFF;
        @(posedge clk); #1;
        chk("rst_mid_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ack", 32'(ack), 32'd0);
        chk("rst_mid_err", 32'(err), 32'd0);
        chk("rst_mid_rdata", 32'(rdata), 32'd0);
        chk("rst_mid_busy0", 32'(busy), 32'd0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_rdata = '0;
        @(negedge clk);
        issue(c_load, 8'h05, 16'h0000); idle_gap();

        // Fetch.
        issue(c_store, 8'h10, 16'h8A07); idle_gap();
        issue(c_fetch, 8'h10, 16'h0000); idle_gap();

        // Illegal opcode leaves rdata and RAM alone.
        issue(c_none, 8'h01, 16'hDEAD); idle_gap();
        issue(c_load, 8'h01, 16'h0000); idle_gap();

        // Back-to-back loads with req held through ack.
        issue(c_load, 8'h05, 16'h0000);
        issue(c_load, 8'h05, 16'h0000);
        issue(c_store, 8'h06, 16'h0BAD);
        idle_gap();

        // Random traffic.
        for (int i = 0; i < 120; i++) begin
            issue(2'($urandom), 8'($urandom), 16'($urandom));
            if ($urandom_range(0, 1) == 0) idle_gap();
        end
        idle_gap();

        // WAIT_CYCLES=0, DEPTH=128.
        xrun(0, c_store, 8'h20, 16'hBEEF, 2, 1'b0, 16'h0000);
        xrun(0, c_load,  8'h20, 16'h0000, 2, 1'b0, 16'hBEEF);
        xrun(0, c_load,  8'hC0, 16'h0000, 2, 1'b1, 16'hBEEF);
        xrun(0, c_none,  8'h01, 16'h0000, 2, 1'b1, 16'hBEEF);
        // WAIT_CYCLES=15.
        xrun(1, c_store, 8'h33, 16'h5A5A, 17, 1'b0, 16'h0000);
        xrun(1, c_load,  8'h33, 16'h0000, 17, 1'b0, 16'h5A5A);

        repeat (5) @(negedge clk);
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the CPU's memory buffer register path.
- Accepts read (instruction fetch / operand load) and write (accumulator store) requests from the MBR/MAR side over a req/ack handshake.
- Services each request from an internal 16-bit word RAM with a configurable number of wait states.
- Returns read data and a one-cycle acknowledge.
- Sits between the MBR/control unit and main memory; it is the far end of the MBR's fetch/load/store transfers.

Parameters:
- DATA_W, 16: word width.
- ADDR_W, 8: address width (matches the MBR's 8-bit address output).
- DEPTH, 256: implemented words; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 1: wait states inserted before each access; legal range 0..15.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 1: request valid; held by the master until ack.
- op, input, 2: 00 none (illegal with req), 01 fetch, 10 load, 11 store.
- addr, input, ADDR_W: word address.
- wdata, input, DATA_W: store data.
- ack, output, 1: one-cycle completion pulse.
- err, output, 1: qualifies ack; high means the request was rejected.
- rdata, output, DATA_W: read data; valid while ack=1 for fetch/load.
- busy, output, 1: high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync deassert by the integrator):
  - State goes to IDLE; ack=0, err=0, rdata=0, busy=0, wait counter=0.
  - RAM contents are not reset and are preserved across reset.
  - Reset mid-transaction aborts it. A pending store is not written if reset occurs before the ACCESS edge.
- States: IDLE, WAIT, ACCESS, ACK.
- IDLE:
  - When req=1 at a clock edge, capture op/addr/wdata into internal registers.
  - Next state is WAIT if WAIT_CYCLES>0, else ACCESS. The wait counter loads WAIT_CYCLES-1.
  - If req=0, stay in IDLE.
- WAIT:
  - Decrement the counter each edge; go to ACCESS when the counter is 0.
  - Inputs are ignored in this state; only the captured values are used.
- ACCESS: one cycle.
  - Legal store: RAM[addr] <= wdata.
  - Legal read: rdata <= RAM[addr] (synchronous read).
  - Illegal request: op==00 or addr ≥ DEPTH. No RAM access, rdata holds its previous value, err is set.
  - Next state is ACK, with ack=1 registered for that cycle.
- ACK:
  - ack=1 and err valid for exactly one cycle, then go to IDLE with ack=0 and err=0.
  - req is ignored during the ACK cycle.
- Back-to-back: if req is still (or again) high in IDLE, a new transaction starts. The master must drop req in the ack cycle unless it intends a new request.
- Latency: for a request sampled at edge k, ack is high in the cycle after edge k+2+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives ack after edge k+2.
  - WAIT_CYCLES=1 gives ack after edge k+3.
- rdata holds its value after ack until the next successful read.
- Stores do not change rdata.
- Inputs changing while busy=1 have no effect.

Decomposition:
- Shared package mem_pkg:
  - Opcode constants OP_NONE=2'b00, OP_FETCH=2'b01, OP_LOAD=2'b10, OP_STORE=2'b11. These are the same encoding as the MBR control field.
  - State encoding IDLE/WAIT/ACCESS/ACK.
  - DATA_W and ADDR_W defaults.
- One sub-module, mem_array: single-port synchronous RAM, DEPTH x DATA_W, with we, addr, wdata, rdata. No reset.
- The FSM, counter and legality check stay in mem_responder.

Test Plan:
All scenarios use WAIT_CYCLES=1 unless stated.
1. Store then load: store 16'h1234 to addr 8'h05, then load 8'h05 → each ack appears 3 edges after req is sampled; the load returns rdata=16'h1234 with err=0.
2. Fetch: store 16'h8A07 at 8'h10, then fetch 8'h10 → rdata=16'h8A07, ack for one cycle, busy high from the edge after req until ack ends.
3. Illegal request: op=00 with req at addr 8'h01 → ack=1 and err=1, rdata unchanged from the prior value, RAM untouched (a follow-up load of 8'h01 returns the old data). With DEPTH=128, a load at 8'hC0 → err=1.
4. Back-to-back: req held high through ack with op=load, addr 8'h05 → a second transaction starts in the next IDLE cycle and a second ack follows 3 edges later. Separately, inputs changed during WAIT are ignored.
5. Reset mid-transaction: store 16'hFFFF to 8'h05 with rst_n pulsed low during WAIT → outputs go to 0 immediately (async); after reset, a load of 8'h05 returns 16'h1234.
6. WAIT_CYCLES=0 and WAIT_CYCLES=15 builds: load latency measures exactly 2 and 17 edges from req sample to ack.
